// File: rtl/trade_report_framer_if.sv
// Trade-report framer bus: trade decisions in, bytes out to uart_tx.
// master = decision source / uart side, slave = the framer.
interface trade_report_framer_if #(
  parameter int unsigned PROFIT_W = 16
);
  logic                in_valid;
  logic [7:0]          in_action;
  logic [PROFIT_W-1:0] in_profit;
  logic                in_ready;
  logic [7:0]          tx_data;
  logic                tx_en;
  logic                tx_busy;

  modport master (
    output in_valid, in_action, in_profit, tx_busy,
    input  in_ready, tx_data, tx_en
  );

  modport slave (
    input  in_valid, in_action, in_profit, tx_busy,
    output in_ready, tx_data, tx_en
  );
endinterface

// File: rtl/trade_report_framer.sv
// Buffered trade-report transmitter between trade_strategy and uart_tx.
// Non-zero decisions are queued in a FIFO and each is sent as
//   HEADER, SEQ, ACTION, PROFIT (MSB byte first), [CHECKSUM], FOOTER
// one byte per tx_en strobe.
// Optional feature: define TRADE_FRAMER_CHECKSUM_EN to insert an XOR checksum
// byte (SEQ ^ ACTION ^ profit bytes) before FOOTER.
module trade_report_framer #(
  parameter int unsigned PROFIT_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = 8'hAA,
  parameter logic [7:0]  FOOTER     = 8'h55
) (
  input  logic                          clk,
  input  logic                          rst,
  trade_report_framer_if.slave          bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count,
  output logic                          idle
);

  localparam int unsigned PB = PROFIT_W / 8;
`ifdef TRADE_FRAMER_CHECKSUM_EN
  localparam int unsigned NB = 5 + PB;
`else
  localparam int unsigned NB = 4 + PB;
`endif
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned EW = 8 + PROFIT_W;
  localparam int unsigned IW = 4;  // NB is at most 9
  localparam logic [IW-1:0] LastIdx = IW'(NB - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGuard, StWait} state_e;

  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic [7:0]          drop_q;
  logic [7:0]          seq_q;
  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q;
  logic [7:0]          pkt_action_q;
  logic [PROFIT_W-1:0] pkt_profit_q;
  logic [7:0]          pkt_seq_q;

  logic          full, push_req, push, drop, pop;
  logic [EW-1:0] head;
  logic [7:0]    byte_sel;
  logic          tx_en_c;
  logic [7:0]    tx_data_c;

  // Fullness is judged on the registered level, so a push while full is
  // rejected even when a pop happens in the same cycle.
  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign push_req = bus.in_valid && (bus.in_action != 8'h00);
  assign push     = push_req && !full;
  assign drop     = push_req && full;
  // Reports stay queued until uart_tx is free, so a stalled link backs up
  // into the FIFO rather than into the packet register.
  assign pop      = (state_q == StIdle) && (level_q != '0) && !bus.tx_busy;
  assign head     = mem_q[rd_ptr_q];

  // Report FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.in_action, bus.in_profit};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (!push && pop) level_q <= level_q - LW'(1);
    end
  end

  // Saturating count of reports rejected on a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  // FSM state plus packet register, byte index and sequence counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      seq_q        <= '0;
      pkt_action_q <= '0;
      pkt_profit_q <= '0;
      pkt_seq_q    <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        pkt_action_q <= head[EW-1 -: 8];
        pkt_profit_q <= head[PROFIT_W-1:0];
      end
      if (state_q == StLoad) begin
        idx_q     <= '0;
        pkt_seq_q <= seq_q;
      end
      if ((state_q == StWait) && !bus.tx_busy) begin
        if (idx_q == LastIdx) seq_q <= seq_q + 8'd1;
        else                  idx_q <= idx_q + IW'(1);
      end
    end
  end

`ifdef TRADE_FRAMER_CHECKSUM_EN
  logic [7:0] csum;

  // XOR checksum over SEQ, ACTION and the profit bytes.
  always_comb begin
    csum = pkt_seq_q ^ pkt_action_q;
    for (int k = 0; k < int'(PB); k++) csum = csum ^ pkt_profit_q[8*k +: 8];
  end
`endif

  // Select the packet byte addressed by the current index.
  always_comb begin
    byte_sel = FOOTER;
    if (idx_q == IW'(0))      byte_sel = HEADER;
    else if (idx_q == IW'(1)) byte_sel = pkt_seq_q;
    else if (idx_q == IW'(2)) byte_sel = pkt_action_q;
    for (int k = 0; k < int'(PB); k++) begin
      if (idx_q == IW'(3 + k)) byte_sel = pkt_profit_q[PROFIT_W-1-8*k -: 8];
    end
`ifdef TRADE_FRAMER_CHECKSUM_EN
    if (idx_q == IW'(3 + PB)) byte_sel = csum;
`endif
  end

  // Next-state logic; tx_en is a one-cycle strobe gated by tx_busy.
  always_comb begin
    state_d   = state_q;
    tx_en_c   = 1'b0;
    tx_data_c = 8'h00;
    unique case (state_q)
      StIdle:  if (pop) state_d = StLoad;
      StLoad:  state_d = StSend;
      StSend: begin
        if (!bus.tx_busy) begin
          tx_en_c   = 1'b1;
          tx_data_c = byte_sel;
          state_d   = StGuard;
        end
      end
      // Covers uart_tx's one-cycle busy rise latency.
      StGuard: state_d = StWait;
      StWait: begin
        if (!bus.tx_busy) state_d = (idx_q == LastIdx) ? StIdle : StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.tx_en    = tx_en_c;
  assign bus.tx_data  = tx_data_c;
  assign bus.in_ready = !full;
  assign fifo_level   = level_q;
  assign drop_count   = drop_q;
  assign idle         = (state_q == StIdle) && (level_q == '0);

endmodule

// File: tb/tb_trade_report_framer.sv
// Scoreboard bench for trade_report_framer: a 16-bit-profit instance for the
// functional tests and a 32-bit-profit instance for the width/SEQ-wrap test.
module tb_trade_report_framer;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  trade_report_framer_if #(.PROFIT_W(16)) b16 ();
  trade_report_framer_if #(.PROFIT_W(32)) b32 ();

  logic [2:0] lvl16, lvl32;
  logic [7:0] drop16, drop32;
  logic       idle16, idle32;

  trade_report_framer #(.PROFIT_W(16), .FIFO_DEPTH(4)) u16 (
    .clk        (clk),
    .rst        (rst),
    .bus        (b16.slave),
    .fifo_level (lvl16),
    .drop_count (drop16),
    .idle       (idle16)
  );

  trade_report_framer #(.PROFIT_W(32), .FIFO_DEPTH(4)) u32 (
    .clk        (clk),
    .rst        (rst),
    .bus        (b32.slave),
    .fifo_level (lvl32),
    .drop_count (drop32),
    .idle       (idle32)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] q16[$];
  logic [7:0] q32[$];
  logic [7:0] seq16 = 8'h00;
  logic [7:0] seq32 = 8'h00;
  int   bytes16 = 0;
  int   bytes32 = 0;
  int   peak16  = 0;
  bit   hold16  = 1'b0;
  bit   en16_seen = 1'b0;
  bit   en32_seen = 1'b0;
  bit   prev16 = 1'b0;
  bit   prev32 = 1'b0;

`ifdef TRADE_FRAMER_CHECKSUM_EN
  localparam int NB16 = 7;
`else
  localparam int NB16 = 6;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Append the expected byte stream of one accepted report to a scoreboard.
  task automatic exp_pkt(input bit w32, input logic [7:0] act, input logic [31:0] prof);
    logic [7:0] b[$];
    logic [7:0] s, cs, pbyte;
    int pb;
    pb = w32 ? 4 : 2;
    s  = w32 ? seq32 : seq16;
    cs = s ^ act;
    b.push_back(8'hAA);
    b.push_back(s);
    b.push_back(act);
    for (int k = pb - 1; k >= 0; k--) begin
      pbyte = prof[8*k +: 8];
      cs    = cs ^ pbyte;
      b.push_back(pbyte);
    end
`ifdef TRADE_FRAMER_CHECKSUM_EN
    b.push_back(cs);
`endif
    b.push_back(8'h55);
    foreach (b[i]) begin
      if (w32) q32.push_back(b[i]);
      else     q16.push_back(b[i]);
    end
    if (w32) seq32 = seq32 + 8'd1;
    else     seq16 = seq16 + 8'd1;
  endtask

  // One-cycle decision strobe; called at posedge+1, returns at posedge+1.
  task automatic push16(input logic [7:0] act, input logic [15:0] prof, input bit accept);
    if (accept) exp_pkt(1'b0, act, {16'h0, prof});
    b16.in_valid  = 1'b1;
    b16.in_action = act;
    b16.in_profit = prof;
    @(posedge clk); #1;
    b16.in_valid  = 1'b0;
  endtask

  task automatic push32(input logic [7:0] act, input logic [31:0] prof);
    exp_pkt(1'b1, act, prof);
    b32.in_valid  = 1'b1;
    b32.in_action = act;
    b32.in_profit = prof;
    @(posedge clk); #1;
    b32.in_valid  = 1'b0;
  endtask

  task automatic wait_idle(input bit w32, input int budget, input string name);
    int n = 0;
    while (n < budget && !(w32 ? (idle32 && q32.size() == 0) : (idle16 && q16.size() == 0)))
    begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, (n >= budget), 0);
  endtask

  // uart_tx stand-ins: busy rises one cycle after tx_en and stays up 3 cycles.
  initial begin
    int cnt = 0;
    b16.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst)           cnt = 0;
      else if (en16_seen) cnt = 3;
      else if (cnt > 0)   cnt--;
      b16.tx_busy = hold16 || (cnt != 0);
    end
  end

  initial begin
    int cnt = 0;
    b32.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst)           cnt = 0;
      else if (en32_seen) cnt = 3;
      else if (cnt > 0)   cnt--;
      b32.tx_busy = (cnt != 0);
    end
  end

  // Monitor: pops the scoreboards on every tx_en and checks the strobe rules.
  initial begin
    forever begin
      @(negedge clk);
      en16_seen = b16.tx_en;
      en32_seen = b32.tx_en;
      if (rst) begin
        if (int'(lvl16) > peak16) peak16 = int'(lvl16);
        if (b16.tx_en) begin
          chk("tx16_strobe", {prev16, b16.tx_busy}, 0);
          if (q16.size() == 0) chk("tx16_unexpected", {24'h0, b16.tx_data}, 32'hFFFF_FFFF);
          else                 chk("tx16_byte", b16.tx_data, q16.pop_front());
          bytes16++;
        end
        if (b32.tx_en) begin
          chk("tx32_strobe", {prev32, b32.tx_busy}, 0);
          if (q32.size() == 0) chk("tx32_unexpected", {24'h0, b32.tx_data}, 32'hFFFF_FFFF);
          else                 chk("tx32_byte", b32.tx_data, q32.pop_front());
          bytes32++;
        end
      end
      prev16 = b16.tx_en;
      prev32 = b32.tx_en;
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, n;
    rst = 1'b0;
    b16.in_valid = 1'b0; b16.in_action = 8'h00; b16.in_profit = '0;
    b32.in_valid = 1'b0; b32.in_action = 8'h00; b32.in_profit = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", lvl16, 0);
    chk("rst_drop", drop16, 0);
    chk("rst_idle", idle16, 1);
    chk("rst_ready", b16.in_ready, 1);
    chk("rst_tx_en", b16.tx_en, 0);
    chk("rst_tx_data", b16.tx_data, 0);
    chk("rst32_idle", idle32, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single report and first-byte latency.
    push16(8'h01, 16'h0123, 1'b1);
    chk("single_level", lvl16, 1);
    chk("single_t0_en", b16.tx_en, 0);
    @(posedge clk); #1;
    chk("single_t1_en", b16.tx_en, 0);
    @(posedge clk); #1;
    chk("single_t2_en", b16.tx_en, 1);
    chk("single_t2_hdr", b16.tx_data, 8'hAA);
    wait_idle(1'b0, 200, "single_drain");

    // Zero action is filtered: no push, no drop, no packet.
    b16.in_valid = 1'b1; b16.in_action = 8'h00; b16.in_profit = 16'hFFFF;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    chk("filter_idle", idle16, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("filter_level", lvl16, 0);
    chk("filter_drop", drop16, 0);
    chk("filter_idle_late", idle16, 1);

    // Back-to-back pushes, link stalled so all three queue up.
    peak16 = 0;
    hold16 = 1'b1;
    @(posedge clk); #1;
    push16(8'h01, 16'h0010, 1'b1);
    push16(8'h02, 16'h0020, 1'b1);
    push16(8'h01, 16'h0030, 1'b1);
    chk("b2b_level", lvl16, 3);
    hold16 = 1'b0;
    wait_idle(1'b0, 600, "b2b_drain");
    chk("b2b_peak", peak16, 3);
    chk("b2b_drop", drop16, 0);

    // Overflow: six pushes into a stalled 4-deep FIFO, then saturation.
    hold16 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push16(8'h02, 16'h1000 + 16'(i), (i < 4));
    chk("ovf_level", lvl16, 4);
    chk("ovf_ready", b16.in_ready, 0);
    chk("ovf_drop", drop16, 2);
    for (int i = 0; i < 255; i++) push16(8'h01, 16'(i), 1'b0);
    chk("ovf_drop_sat", drop16, 255);
    base = bytes16;
    hold16 = 1'b0;
    wait_idle(1'b0, 1000, "ovf_drain");
    chk("ovf_bytes", bytes16 - base, 4 * NB16);

    // Reset after the third byte of a packet with two reports queued.
    base = bytes16;
    push16(8'h01, 16'hAAAA, 1'b1);
    push16(8'h02, 16'hBBBB, 1'b1);
    push16(8'h01, 16'hCCCC, 1'b1);
    n = 0;
    while (bytes16 < base + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_reach", (n >= 200), 0);
    chk("midrst_queued", lvl16, 2);
    #1;
    rst = 1'b0;
    q16.delete(); q32.delete();
    seq16 = 8'h00; seq32 = 8'h00;
    #1;
    chk("midrst_tx_en", b16.tx_en, 0);
    chk("midrst_tx_data", b16.tx_data, 0);
    chk("midrst_level", lvl16, 0);
    chk("midrst_drop", drop16, 0);
    chk("midrst_idle", idle16, 1);
    chk("midrst_ready", b16.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push16(8'h02, 16'hBEEF, 1'b1);
    wait_idle(1'b0, 200, "midrst_post_drain");

    // 32-bit profit width, then SEQ wrap over 256 further packets.
    push32(8'h02, 32'hDEADBEEF);
    wait_idle(1'b1, 300, "w32_drain");
    for (int i = 0; i < 256; i++) begin
      push32(8'h01, 32'(i) * 32'h0101_0001);
      wait_idle(1'b1, 300, "wrap_drain");
    end
    chk("wrap_seq_model", seq32, 8'h01);
    chk("wrap_bytes32", bytes32, 257 * (NB16 + 2));

    chk("end_q16_empty", q16.size(), 0);
    chk("end_q32_empty", q32.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
